overture_core_param: RTL and testbench
======================================

Name: overture_core_param

Overview:
- Parametrised next-generation Overture-ISA core. Generalised in data width and program depth.
- Adds internal writable program memory, valid/ready I/O handshakes, single-step mode and a sticky halt on self-jump.
- Sits under the per-program wrapper modules. Each wrapper loads its program through the load port, then drives run/step.
- One instruction per executing cycle.

Parameters:
- DATA_W, 8, register and I/O data width (>=8).
- PC_W, 8, program counter width. Program memory holds 2**PC_W 8-bit instructions.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- run  in  1  free-run enable (level)
- step  in  1  while run=0, each cycle high executes one instruction
- in_port  in  DATA_W  input data
- in_valid  in  1  in_port valid
- in_ready  out  1  core consuming input this cycle
- out_port  out  DATA_W  last output value (registered)
- out_valid  out  1  one-cycle pulse when out_port is updated
- prog_we  in  1  program write strobe
- prog_addr  in  PC_W  program write address
- prog_wdata  in  8  program write data
- pc  out  PC_W  current program counter
- instr_debug  out  8  instruction at pc (mem[pc], combinational)
- halted  out  1  sticky halt flag
- r0_out..r5_out  out  DATA_W each  register file contents

Behaviour:
- Reset values: pc=0, r0..r5=0, out_port=0, out_valid=0, halted=0. Program memory is not reset and keeps its contents.
- Execute enable: exec = !halted & (run | step). When exec=0, no architectural state changes and out_valid=0.
- Program load: write when prog_we & !run. Ignored when run=1. Legal while halted.
- Instruction classes (bits [7:6]):
  - 00 IMM: r0 = zero-extended instr[5:0].
  - 01 ALU: r3 = f(r1, r2), op = instr[2:0]. 0 OR, 1 NAND, 2 NOR, 3 AND, 4 ADD, 5 SUB (r1-r2), 6 XOR, 7 XNOR. Results modulo 2**DATA_W; carries discarded.
  - 10 COPY: src = instr[5:3], dst = instr[2:0]. Index 0-5 is a register, 6 is I/O, 7 is reserved. src 7 reads 0; dst 7 discards the value.
  - 11 BRANCH: test r3 as signed DATA_W. cond 0 never, 1 ==0, 2 <0, 3 <=0, 4 always, 5 !=0, 6 >=0, 7 >0. If taken, pc = r0[PC_W-1:0].
- PC sequencing: if not taken, pc = pc+1, wrapping from 2**PC_W-1 to 0.
- Input handshake: in_ready = exec & COPY & src==6.
  - If in_ready & !in_valid: stall. No pc or register change.
  - If in_ready & in_valid: dst gets in_port and pc advances in that cycle.
- Output: COPY with dst==6 registers out_port = source value and pulses out_valid=1 for the next cycle only. Back-to-back output copies give consecutive pulses.
- COPY 6 to 6: consumes input (handshake as above) and emits it on out_port.
- Halt: an executed BRANCH with cond 4 and r0[PC_W-1:0]==pc sets halted=1 and leaves pc unchanged. halted is cleared only by reset.
- Conditional self-jumps (cond 1-3, 5-7) that are taken loop without halting.
- Step: run=0, step held N cycles executes N instructions, stalls included. run=1 ignores step.
- Reset mid-stall or mid-output: state returns to reset values immediately. Any out_valid pulse in flight is dropped.

Test Plan:
1. Load 05 81 02 82 44 9E, then run=1. After 6 cycles: r1=5, r2=2, r3=7, out_port=7, out_valid high exactly 1 cycle.
2. Load B0 (COPY in to r0), run=1, in_valid=0 for 3 cycles. Required: in_ready=1, pc=0 held. Then in_valid=1, in_port=0x2A gives r0=0x2A, pc=1 next cycle.
3. Branch sign: program sets r1=0, r2=1, SUB gives r3=0xFF, r0=0x10, then C2 (<0). Required: pc=0x10. With C7 (>0) in place of C2: pc=previous+1.
4. Halt: 06 at 0; C4 at 6 with r0=6 and NOPs (80 = COPY r0 to r0) between. Required: pc reaches 6, halted=1, pc frozen for 10 cycles, prog write then accepted with run=0.
5. Step mode: run=0, pulse step 3 single cycles on program 1. Required: pc=3, r2 still 0; step held 3 cycles gives pc=6.
6. DATA_W=16, PC_W=4: IMM 3F gives r0=0x003F. pc wraps 15 to 0. SUB 0-1 gives 0xFFFF. prog_we with run=1 leaves memory unchanged.

Source files
------------

// File: rtl/overture_core_param.sv
// overture_core_param: parametrised Overture-ISA core with writable
// program memory, valid/ready I/O, single-step and sticky self-jump halt.
module overture_core_param #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              step,
  input  logic [DATA_W-1:0] in_port,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_port,
  output logic              out_valid,
  input  logic              prog_we,
  input  logic [PC_W-1:0]   prog_addr,
  input  logic [7:0]        prog_wdata,
  output logic [PC_W-1:0]   pc,
  output logic [7:0]        instr_debug,
  output logic              halted,
  output logic [DATA_W-1:0] r0_out,
  output logic [DATA_W-1:0] r1_out,
  output logic [DATA_W-1:0] r2_out,
  output logic [DATA_W-1:0] r3_out,
  output logic [DATA_W-1:0] r4_out,
  output logic [DATA_W-1:0] r5_out
);

  localparam int DEPTH = 1 << PC_W;

  logic [7:0]        r_mem [DEPTH];
  logic [PC_W-1:0]   r_pc;
  logic [DATA_W-1:0] r_regs [6];
  logic [DATA_W-1:0] r_out;
  logic              r_out_valid;
  logic              r_halted;

  logic [7:0]        w_instr;
  logic              w_exec;
  logic              w_imm;
  logic              w_alu;
  logic              w_copy;
  logic              w_br;
  logic [2:0]        w_src;
  logic [2:0]        w_dst;
  logic              w_stall;
  logic              w_adv;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_alu_res;
  logic [DATA_W-1:0] w_src_val;
  logic              w_z;
  logic              w_n;
  logic              w_cond;
  logic              w_taken;
  logic              w_halt;
  logic [PC_W-1:0]   w_pc_next;

  assign w_instr = r_mem[r_pc];
  assign w_exec  = ~r_halted & (run | step);
  assign w_imm   = w_instr[7:6] == 2'b00;
  assign w_alu   = w_instr[7:6] == 2'b01;
  assign w_copy  = w_instr[7:6] == 2'b10;
  assign w_br    = w_instr[7:6] == 2'b11;
  assign w_src   = w_instr[5:3];
  assign w_dst   = w_instr[2:0];

  assign in_ready = w_exec & w_copy & (w_src == 3'd6);
  assign w_stall  = in_ready & ~in_valid;
  assign w_adv    = w_exec & ~w_stall;

  assign w_a = r_regs[1];
  assign w_b = r_regs[2];
  assign w_z = r_regs[3] == '0;
  assign w_n = r_regs[3][DATA_W-1];

  // ALU result for r3
  always_comb begin
    w_alu_res = '0;
    unique case (w_instr[2:0])
      3'd0: w_alu_res = w_a | w_b;
      3'd1: w_alu_res = ~(w_a & w_b);
      3'd2: w_alu_res = ~(w_a | w_b);
      3'd3: w_alu_res = w_a & w_b;
      3'd4: w_alu_res = w_a + w_b;
      3'd5: w_alu_res = w_a - w_b;
      3'd6: w_alu_res = w_a ^ w_b;
      3'd7: w_alu_res = ~(w_a ^ w_b);
    endcase
  end

  // COPY source select: registers, I/O input, reserved reads zero
  always_comb begin
    w_src_val = '0;
    if (w_src < 3'd6) begin
      w_src_val = r_regs[w_src];
    end else if (w_src == 3'd6) begin
      w_src_val = in_port;
    end
  end

  // branch condition on r3 viewed as signed
  always_comb begin
    w_cond = 1'b0;
    unique case (w_instr[2:0])
      3'd0: w_cond = 1'b0;
      3'd1: w_cond = w_z;
      3'd2: w_cond = w_n;
      3'd3: w_cond = w_z | w_n;
      3'd4: w_cond = 1'b1;
      3'd5: w_cond = ~w_z;
      3'd6: w_cond = ~w_n;
      3'd7: w_cond = ~w_z & ~w_n;
    endcase
  end

  assign w_taken   = w_br & w_cond;
  assign w_halt    = w_br & (w_instr[2:0] == 3'd4)
                   & (r_regs[0][PC_W-1:0] == r_pc);
  assign w_pc_next = w_taken ? r_regs[0][PC_W-1:0] : r_pc + 1'b1;

  // program memory: loadable only while not free-running, never reset
  always_ff @(posedge clk) begin
    if (prog_we && !run) begin
      r_mem[prog_addr] <= prog_wdata;
    end
  end

  // architectural state update, one instruction per executing cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc        <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_halted    <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_out_valid <= 1'b0;
      if (w_adv) begin
        r_pc <= w_pc_next;
        if (w_imm) begin
          r_regs[0] <= {{(DATA_W-6){1'b0}}, w_instr[5:0]};
        end
        if (w_alu) begin
          r_regs[3] <= w_alu_res;
        end
        if (w_copy && w_dst < 3'd6) begin
          r_regs[w_dst] <= w_src_val;
        end
        if (w_copy && w_dst == 3'd6) begin
          r_out       <= w_src_val;
          r_out_valid <= 1'b1;
        end
        if (w_halt) begin
          r_halted <= 1'b1;
        end
      end
    end
  end

  assign pc          = r_pc;
  assign instr_debug = w_instr;
  assign halted      = r_halted;
  assign out_port    = r_out;
  assign out_valid   = r_out_valid;
  assign r0_out      = r_regs[0];
  assign r1_out      = r_regs[1];
  assign r2_out      = r_regs[2];
  assign r3_out      = r_regs[3];
  assign r4_out      = r_regs[4];
  assign r5_out      = r_regs[5];

endmodule

// File: tb/tb_overture_core_param.sv
// tb_overture_core_param: directed program checks plus randomized
// run/step/handshake/load traffic against a behavioural ISA model.
module tb_overture_core_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, run, step, in_valid, prog_we;
  logic [7:0] in_port, prog_addr, prog_wdata;
  logic       in_ready, out_valid, halted;
  logic [7:0] out_port, pc, instr_debug;
  logic [7:0] r_o [6];

  logic        s_run, s_step, s_in_valid, s_prog_we;
  logic [15:0] s_in_port;
  logic [3:0]  s_prog_addr;
  logic [7:0]  s_prog_wdata;
  logic        s_in_ready, s_out_valid, s_halted;
  logic [15:0] s_out_port;
  logic [3:0]  s_pc;
  logic [7:0]  s_instr;
  logic [15:0] s_r [6];

  overture_core_param dut (
    .clk(clk), .reset(reset), .run(run), .step(step),
    .in_port(in_port), .in_valid(in_valid), .in_ready(in_ready),
    .out_port(out_port), .out_valid(out_valid),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .pc(pc), .instr_debug(instr_debug), .halted(halted),
    .r0_out(r_o[0]), .r1_out(r_o[1]), .r2_out(r_o[2]),
    .r3_out(r_o[3]), .r4_out(r_o[4]), .r5_out(r_o[5])
  );

  overture_core_param #(.DATA_W(16), .PC_W(4)) dut16 (
    .clk(clk), .reset(reset), .run(s_run), .step(s_step),
    .in_port(s_in_port), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .out_port(s_out_port), .out_valid(s_out_valid),
    .prog_we(s_prog_we), .prog_addr(s_prog_addr),
    .prog_wdata(s_prog_wdata),
    .pc(s_pc), .instr_debug(s_instr), .halted(s_halted),
    .r0_out(s_r[0]), .r1_out(s_r[1]), .r2_out(s_r[2]),
    .r3_out(s_r[3]), .r4_out(s_r[4]), .r5_out(s_r[5])
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] m_mem [256];
  logic [7:0] m_r [6];
  int         m_pc;
  logic [7:0] m_out;
  bit         m_ov;
  bit         m_halt;

  logic [7:0] q [$];
  int         pulses;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] alu(input int op, input int x,
                                     input int y);
    int r;
    case (op)
      0: r = x | y;
      1: r = 255 - (x & y);
      2: r = 255 - (x | y);
      3: r = x & y;
      4: r = (x + y) % 256;
      5: r = (x - y + 256) % 256;
      6: r = x ^ y;
      default: r = 255 - (x ^ y);
    endcase
    return 8'(r);
  endfunction

  function automatic bit cond_ok(input int c, input logic [7:0] v);
    int s;
    s = (v >= 128) ? int'(v) - 256 : int'(v);
    case (c)
      0: return 1'b0;
      1: return s == 0;
      2: return s < 0;
      3: return s <= 0;
      4: return 1'b1;
      5: return s != 0;
      6: return s >= 0;
      default: return s > 0;
    endcase
  endfunction

  task automatic model_rst();
    m_pc = 0;
    m_out = 8'h00;
    m_ov = 1'b0;
    m_halt = 1'b0;
    for (int i = 0; i < 6; i++) m_r[i] = 8'h00;
  endtask

  task automatic check_all();
    chk("pc", pc, m_pc);
    chk("halted", halted, m_halt);
    chk("out_port", out_port, m_out);
    chk("out_valid", out_valid, m_ov);
    for (int i = 0; i < 6; i++) chk("reg", r_o[i], m_r[i]);
  endtask

  task automatic tick();
    logic [7:0] ins, v;
    bit ex, rdy, nov;
    int nxt, src, dst;
    #1;
    ins = m_mem[m_pc];
    ex = !m_halt && (run || step);
    rdy = ex && ins[7:6] == 2'd2 && ins[5:3] == 3'd6;
    chk("in_ready", in_ready, rdy);
    chk("instr_dbg", instr_debug, ins);
    nov = 1'b0;
    if (ex && !(rdy && !in_valid)) begin
      nxt = (m_pc + 1) % 256;
      src = ins[5:3];
      dst = ins[2:0];
      case (ins[7:6])
        2'd0: m_r[0] = ins & 8'h3f;
        2'd1: m_r[3] = alu(ins[2:0], m_r[1], m_r[2]);
        2'd2: begin
          v = (src < 6) ? m_r[src] : (src == 6) ? in_port : 8'h00;
          if (dst < 6) m_r[dst] = v;
          else if (dst == 6) begin
            m_out = v;
            nov = 1'b1;
          end
        end
        default: begin
          if (cond_ok(ins[2:0], m_r[3])) begin
            if (ins[2:0] == 3'd4 && int'(m_r[0]) == m_pc) m_halt = 1'b1;
            nxt = m_r[0];
          end
        end
      endcase
      m_pc = nxt;
    end
    m_ov = nov;
    if (prog_we && !run) m_mem[prog_addr] = prog_wdata;
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    prog_we = 0; run = 0; step = 0; in_valid = 0;
    s_prog_we = 0; s_run = 0; s_step = 0; s_in_valid = 0;
    reset = 1'b1;
    #1;
    model_rst();
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic load(input int base, input logic [7:0] p [$]);
    for (int i = 0; i < p.size(); i++) begin
      prog_we = 1'b1;
      prog_addr = 8'(base + i);
      prog_wdata = p[i];
      tick();
    end
    prog_we = 1'b0;
  endtask

  initial begin
    reset = 1; run = 0; step = 0; in_valid = 0; in_port = 0;
    prog_we = 0; prog_addr = 0; prog_wdata = 0;
    s_run = 0; s_step = 0; s_in_valid = 0; s_in_port = 0;
    s_prog_we = 0; s_prog_addr = 0; s_prog_wdata = 0;
    for (int i = 0; i < 256; i++) m_mem[i] = 8'hxx;

    do_reset();
    chk("rst_pc", pc, 0);
    chk("rst_halt", halted, 0);
    q = {};
    for (int i = 0; i < 256; i++) q.push_back(8'h80);
    load(0, q);

    // 1: immediate, copy, add, output
    q = {8'h05, 8'h81, 8'h02, 8'h82, 8'h44, 8'h9E};
    do_reset();
    load(0, q);
    run = 1;
    pulses = 0;
    repeat (6) begin tick(); pulses += int'(out_valid); end
    chk("t1_r1", r_o[1], 5);
    chk("t1_r2", r_o[2], 2);
    chk("t1_r3", r_o[3], 7);
    chk("t1_out", out_port, 7);
    repeat (2) begin tick(); pulses += int'(out_valid); end
    chk("t1_pulses", pulses, 1);
    do_reset();
    run = 1;
    repeat (6) tick();
    do_reset();
    chk("rst_drop_ov", out_valid, 0);

    // 2: input stall then handshake
    q = {8'hB0};
    load(0, q);
    run = 1;
    in_valid = 0;
    repeat (3) tick();
    chk("t2_ready", in_ready, 1);
    chk("t2_pc_hold", pc, 0);
    in_port = 8'h2A;
    in_valid = 1;
    tick();
    chk("t2_r0", r_o[0], 8'h2A);
    chk("t2_pc", pc, 1);
    run = 0;
    in_valid = 0;

    // 3: branch on signed r3
    q = {8'h00, 8'h81, 8'h01, 8'h82, 8'h45, 8'h10, 8'hC2};
    do_reset();
    load(0, q);
    run = 1;
    repeat (7) tick();
    chk("t3_neg_r3", r_o[3], 8'hFF);
    chk("t3_lt_taken", pc, 8'h10);
    q = {8'hC7};
    do_reset();
    load(6, q);
    run = 1;
    repeat (7) tick();
    chk("t3_gt_not", pc, 7);

    // 4: sticky halt on self-jump
    q = {8'h06, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'hC4};
    do_reset();
    load(0, q);
    run = 1;
    repeat (7) tick();
    chk("t4_pc", pc, 6);
    chk("t4_halt", halted, 1);
    repeat (10) tick();
    chk("t4_frozen", pc, 6);
    run = 0;
    q = {8'h07};
    load(6, q);
    chk("t4_load", instr_debug, 8'h07);

    // 5: single-step
    q = {8'h05, 8'h81, 8'h02, 8'h82, 8'h44, 8'h9E};
    do_reset();
    load(0, q);
    repeat (3) begin
      step = 1; tick();
      step = 0; tick();
    end
    chk("t5_pc", pc, 3);
    chk("t5_r2", r_o[2], 0);
    step = 1;
    repeat (3) tick();
    step = 0;
    chk("t5_held", pc, 6);

    // 6: 16-bit data, 4-bit pc instance
    do_reset();
    q = {8'h00, 8'h81, 8'h01, 8'h82, 8'h45, 8'h3F};
    for (int i = 0; i < 10; i++) q.push_back(8'h80);
    for (int i = 0; i < 16; i++) begin
      s_prog_we = 1;
      s_prog_addr = 4'(i);
      s_prog_wdata = q[i];
      tick();
    end
    s_prog_we = 0;
    s_run = 1;
    repeat (6) tick();
    chk("t6_imm", s_r[0], 16'h003F);
    chk("t6_sub", s_r[3], 16'hFFFF);
    repeat (10) tick();
    chk("t6_wrap", s_pc, 0);
    s_prog_we = 1;
    s_prog_addr = 4'd1;
    s_prog_wdata = 8'hC4;
    tick();
    s_prog_we = 0;
    s_run = 0;
    #1;
    chk("t6_pc", s_pc, 1);
    chk("t6_we_run", s_instr, 8'h81);
    chk("t6_ov", s_out_valid, 0);

    // random traffic against the model
    for (int rnd = 0; rnd < 8; rnd++) begin
      do_reset();
      q = {};
      for (int i = 0; i < 64; i++) q.push_back(8'($urandom));
      load(0, q);
      repeat (150) begin
        run = $urandom_range(0, 3) != 0;
        step = 1'($urandom_range(0, 1));
        in_valid = 1'($urandom_range(0, 1));
        in_port = 8'($urandom);
        prog_we = $urandom_range(0, 9) == 0;
        prog_addr = 8'($urandom);
        prog_wdata = 8'($urandom);
        tick();
      end
      prog_we = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
